alu_check_sequencer: RTL
========================

// Module: alu_check_sequencer
// PURPOSE
//  Drives one operation at a time into the combinational 4-bit ALU (a, b, s -> f) and checks
//  the returned f against an internal golden model. Requests arrive over a valid/ready port;
//  one verdict per request leaves over a valid/ready port. Saturating pass/fail counters are
//  kept. Used as the on-chip self-test front end in the ALU's own clock domain.
// PARAMETERS
//  W        4   operand/result width; matches the ALU
//  SETTLE   1   cycles the ALU inputs are held before f is sampled; 1..15
//  CNT_W    16  width of the pass/fail counters
// PORTS
//  clk        in   1      single clock; all logic on the rising edge
//  rst        in   1      synchronous, active-high reset
//  req_valid  in   1      request present
//  req_ready  out  1      sequencer can accept a request
//  req_a      in   W      operand a
//  req_b      in   W      operand b
//  req_s      in   2      op: 00 add, 01 sub, 10 shift, 11 and
//  alu_a      out  W      to ALU a
//  alu_b      out  W      to ALU b
//  alu_s      out  2      to ALU s
//  alu_f      in   W      from ALU f
//  rsp_valid  out  1      verdict present
//  rsp_ready  in   1      consumer accepts the verdict
//  rsp_pass   out  1      1 = alu_f matched the expected value
//  rsp_exp    out  W      expected value
//  rsp_got    out  W      sampled alu_f
//  pass_cnt   out  CNT_W  saturating count of passes
//  fail_cnt   out  CNT_W  saturating count of fails
// BEHAVIOUR
//  - Reset: state IDLE; req_ready=1; rsp_valid=0; alu_a/b/s, rsp_exp/got, rsp_pass,
//    pass_cnt, fail_cnt all 0. Reset mid-operation drops the request with no verdict.
//  - Golden model (modulo 2^W): 00 a+b; 01 a-b; 10 a<<b[1:0] with zero fill; 11 a&b.
//  - FSM IDLE: req_ready=1. On req_valid&&req_ready, latch a/b/s into alu_*, load the
//    settle counter with SETTLE, latch exp, go to DRIVE. req_ready is 0 in every other state.
//  - FSM DRIVE: alu_* held stable; counter decrements each cycle; at 1 go to SAMPLE.
//  - FSM SAMPLE (1 cycle): rsp_got<=alu_f; rsp_pass<=(alu_f==exp); bump the matching counter
//    (saturating at all-ones; no wrap); go to RESP.
//  - FSM RESP: rsp_valid=1 with all rsp_* stable until rsp_valid&&rsp_ready, then go to IDLE.
//    A new request is accepted on the cycle after that handshake, never the same cycle.
//  - Latency: request accept to rsp_valid = SETTLE+2 cycles; throughput is 1 op per SETTLE+3
//    cycles when rsp_ready is held at 1.
//  - alu_* keep the last operation after RESP until the next accept.
// CONFIGURATION
//  ALU_CHK_STICKY_EN defined: adds outputs first_fail_vld (1), first_fail_op (2+2W: s,a,b).
//    These capture the first failing operation after reset and hold it until rst.
//    first_fail_vld is set in the SAMPLE cycle of that fail.
//  Not defined: those ports do not exist; no sticky state is kept.
// TESTING
//  1 a=0101 b=1100 s=00, good ALU -> rsp_exp=0001, rsp_pass=1, pass_cnt=1, latency 3 @SETTLE=1
//  2 a=1001 b=0111 s=01 -> exp 0010 pass; a=0011 b=1010 s=10 -> exp 1100 pass;
//    a=1111 b=1100 s=11 -> exp 1100 pass
//  3 alu_f forced to 0000 for add 0101+1100 -> rsp_pass=0, rsp_got=0000, fail_cnt=1
//    (STICKY_EN: first_fail_op={00,0101,1100})
//  4 rsp_ready=0 for 5 cycles in RESP -> rsp_* stable, req_ready=0, request waiting is held off
//  5 CNT_W=2, 5 passing ops -> pass_cnt stops at 11
//  6 rst pulsed during DRIVE -> no rsp_valid; all outputs 0; next request completes normally

Source files
------------

// File: rtl/alu_check_sequencer.sv
// rtl/alu_check_sequencer.sv - self-test sequencer driving a 4-bit ALU and checking f against a golden model
// Optional sticky first-fail capture is built when ALU_CHK_STICKY_EN is defined.
module alu_check_sequencer #(
    parameter int W      = 4,
    parameter int SETTLE = 1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [W-1:0]     req_a,
    input  logic [W-1:0]     req_b,
    input  logic [1:0]       req_s,
    output logic [W-1:0]     alu_a,
    output logic [W-1:0]     alu_b,
    output logic [1:0]       alu_s,
    input  logic [W-1:0]     alu_f,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_pass,
    output logic [W-1:0]     rsp_exp,
    output logic [W-1:0]     rsp_got,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt
`ifdef ALU_CHK_STICKY_EN
    ,
    output logic             first_fail_vld,
    output logic [2*W+1:0]   first_fail_op
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [3:0]  settle_cnt;
    logic [W-1:0] golden;
    logic        accept;
    logic        match;

    always_comb begin
        golden = '0;
        case (req_s)
            2'b00:   golden = req_a + req_b;
            2'b01:   golden = req_a - req_b;
            2'b10:   golden = req_a << req_b[1:0];
            default: golden = req_a & req_b;
        endcase
    end

    assign accept = req_valid && req_ready;
    assign match  = (alu_f == rsp_exp);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_next = DRIVE;
            end
            DRIVE: begin
                if (settle_cnt <= 4'd1) state_next = SAMPLE;
            end
            SAMPLE: begin
                state_next = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_s      <= '0;
            settle_cnt <= '0;
            rsp_exp    <= '0;
            rsp_got    <= '0;
            rsp_pass   <= 1'b0;
            pass_cnt   <= '0;
            fail_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        alu_a      <= req_a;
                        alu_b      <= req_b;
                        alu_s      <= req_s;
                        settle_cnt <= 4'(SETTLE);
                        rsp_exp    <= golden;
                    end
                end
                DRIVE: begin
                    settle_cnt <= settle_cnt - 4'd1;
                end
                SAMPLE: begin
                    rsp_got  <= alu_f;
                    rsp_pass <= match;
                    // Counters hold at all-ones rather than wrapping.
                    if (match) begin
                        if (pass_cnt != {CNT_W{1'b1}}) pass_cnt <= pass_cnt + 1'b1;
                    end else begin
                        if (fail_cnt != {CNT_W{1'b1}}) fail_cnt <= fail_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ALU_CHK_STICKY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            first_fail_vld <= 1'b0;
            first_fail_op  <= '0;
        end else if (state == SAMPLE && !match && !first_fail_vld) begin
            first_fail_vld <= 1'b1;
            first_fail_op  <= {alu_s, alu_a, alu_b};
        end
    end
`endif

endmodule
